// File: rtl/gerencia_pkg.sv
// Shared constants and action encoding for the PC/context manager.
package gerencia_pkg;
  localparam int DEF_HALT_VEC = 67;
  localparam int DEF_CTX_VEC  = 68;
  localparam int DEF_OS_ENTRY = 0;
  localparam int OS_ID        = 0;

  typedef enum logic [1:0] {ACT_NORMAL, ACT_HALT, ACT_RETOMA, ACT_SWITCH} acao_e;
endpackage

// File: rtl/contexto_tab.sv
// Per-process saved-PC table: save port beats carga port on the same entry.
module contexto_tab #(
  parameter int WIDTH = 32,
  parameter int NPROC = 4,
  parameter int IDW   = $clog2(NPROC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             saveEn,
  input  logic [IDW-1:0]   saveId,
  input  logic [WIDTH-1:0] saveData,
  input  logic             loadEn,
  input  logic [IDW-1:0]   loadId,
  input  logic [WIDTH-1:0] loadData,
  input  logic [IDW-1:0]   rdId,
  output logic [WIDTH-1:0] rdData
);
  logic [NPROC-1:0][WIDTH-1:0] tab;

  // Entry 0 belongs to the OS and is never written, so it always reads 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tab <= '0;
    end else begin
      for (int i = 1; i < NPROC; i++) begin
        if (saveEn && saveId == IDW'(i))      tab[i] <= saveData;
        else if (loadEn && loadId == IDW'(i)) tab[i] <= loadData;
      end
    end
  end

  assign rdData = tab[rdId];
endmodule

// File: rtl/gerencia_pc_ctx.sv
// PC register with process ownership, context save/restore and optional time slice.
module gerencia_pc_ctx
  import gerencia_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NPROC    = 4,
  parameter int               IDW      = $clog2(NPROC),
  parameter logic [WIDTH-1:0] HALT_VEC = WIDTH'(DEF_HALT_VEC),
  parameter logic [WIDTH-1:0] CTX_VEC  = WIDTH'(DEF_CTX_VEC),
  parameter logic [WIDTH-1:0] OS_ENTRY = WIDTH'(DEF_OS_ENTRY),
  parameter int               QUANTUM  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] novo_pc,
  input  logic             halt,
  input  logic             troca_ctx,
  input  logic             retoma,
  input  logic             carga,
  input  logic [IDW-1:0]   id_alvo,
  input  logic [WIDTH-1:0] pc_carga,
  output logic [WIDTH-1:0] atual_pc,
  output logic [IDW-1:0]   id_proc,
  output logic             quantum_exp,
  output logic [WIDTH-1:0] pc_salvo,
  output logic [NPROC-1:0] ativo
);
  localparam logic [IDW-1:0] OSID  = IDW'(OS_ID);
  localparam int             CW    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0]  QLAST = (QUANTUM > 0) ? CW'(QUANTUM - 1) : '0;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tabRd;
  logic             expira, retOk, swOk;
  acao_e            acao;

  assign expira = (QUANTUM > 0) && (id_proc != OSID) && (cnt == QLAST);
  assign retOk  = retoma && (id_proc == OSID) && (id_alvo != OSID);
  assign swOk   = (id_proc != OSID) && (troca_ctx || expira);

  always_comb begin
    acao = ACT_NORMAL;
    if (halt)       acao = ACT_HALT;
    else if (retOk) acao = ACT_RETOMA;
    else if (swOk)  acao = ACT_SWITCH;
  end

  contexto_tab #(.WIDTH(WIDTH), .NPROC(NPROC), .IDW(IDW)) uTab (
    .clk      (clk),
    .reset    (reset),
    .saveEn   (acao == ACT_SWITCH),
    .saveId   (id_proc),
    .saveData (novo_pc),
    .loadEn   (carga),
    .loadId   (id_alvo),
    .loadData (pc_carga),
    .rdId     (id_alvo),
    .rdData   (tabRd)
  );

  assign pc_salvo = tabRd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      atual_pc    <= OS_ENTRY;
      id_proc     <= OSID;
      quantum_exp <= 1'b0;
      cnt         <= '0;
      ativo       <= NPROC'(1);
    end else begin
      quantum_exp <= 1'b0;
      unique case (acao)
        ACT_HALT: begin
          if (id_proc == OSID) begin
            atual_pc <= OS_ENTRY;
          end else begin
            atual_pc       <= HALT_VEC;
            ativo[id_proc] <= 1'b0;
            id_proc        <= OSID;
            cnt            <= '0;
          end
        end
        ACT_RETOMA: begin
          atual_pc       <= tabRd;
          id_proc        <= id_alvo;
          ativo[id_alvo] <= 1'b1;
          cnt            <= '0;
        end
        ACT_SWITCH: begin
          atual_pc    <= CTX_VEC;
          id_proc     <= OSID;
          cnt         <= '0;
          quantum_exp <= expira;
        end
        default: begin
          atual_pc <= novo_pc;
          if ((QUANTUM > 0) && (id_proc != OSID)) cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gerencia_pc_ctx.sv
// Scoreboard bench: driver pushes model expectations, monitor compares after each edge.
module tb_gerencia_pc_ctx;
  localparam int W = 32, NP = 4, IW = 2, Q = 5;

  logic          clk = 0, reset = 1;
  logic [W-1:0]  novo_pc = '0, pc_carga = '0;
  logic          halt = 0, troca_ctx = 0, retoma = 0, carga = 0;
  logic [IW-1:0] id_alvo = '0;
  logic [W-1:0]  atual_pc, pc_salvo;
  logic [IW-1:0] id_proc;
  logic          quantum_exp;
  logic [NP-1:0] ativo;

  always #5 clk = ~clk;

  gerencia_pc_ctx #(.WIDTH(W), .NPROC(NP), .QUANTUM(Q)) dut (
    .clk(clk), .reset(reset), .novo_pc(novo_pc), .halt(halt), .troca_ctx(troca_ctx),
    .retoma(retoma), .carga(carga), .id_alvo(id_alvo), .pc_carga(pc_carga),
    .atual_pc(atual_pc), .id_proc(id_proc), .quantum_exp(quantum_exp),
    .pc_salvo(pc_salvo), .ativo(ativo)
  );

  typedef struct packed {
    logic [W-1:0]  pc;
    logic [IW-1:0] id;
    logic          qe;
    logic [NP-1:0] at;
    logic [W-1:0]  ps;
  } obs_t;

  obs_t  expQ[$];
  string nameQ[$];
  int    checks = 0, errors = 0;

  // Reference: the process table, who runs, who is alive, and how much slice is used.
  logic [W-1:0]  mPc;
  logic [W-1:0]  mTab[NP];
  logic [IW-1:0] mId;
  logic [NP-1:0] mAt;
  int            mUsed;

  task automatic mreset();
    mPc = '0; mId = '0; mAt = NP'(1); mUsed = 0;
    for (int i = 0; i < NP; i++) mTab[i] = '0;
  endtask

  task automatic drive(input logic h, t, r, c, input logic [IW-1:0] ida,
                       input logic [W-1:0] pcc, nv, input string nm);
    logic [W-1:0] nt[NP];
    logic qe;
    qe = 1'b0;
    halt = h; troca_ctx = t; retoma = r; carga = c;
    id_alvo = ida; pc_carga = pcc; novo_pc = nv;
    nt = mTab;
    if (c && ida != 0) nt[ida] = pcc;
    if (h) begin
      if (mId == 0) mPc = 0;
      else begin mAt[mId] = 1'b0; mId = 0; mPc = 67; mUsed = 0; end
    end else if (r && mId == 0 && ida != 0) begin
      mPc = mTab[ida]; mId = ida; mAt[ida] = 1'b1; mUsed = 0;
    end else if (mId != 0 && (t || mUsed + 1 == Q)) begin
      qe = (mUsed + 1 == Q);
      nt[mId] = nv; mPc = 68; mId = 0; mUsed = 0;
    end else begin
      mPc = nv;
      if (mId != 0) mUsed++;
    end
    mTab = nt;
    expQ.push_back('{mPc, mId, qe, mAt, mTab[ida]});
    nameQ.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    drive(0, 0, 0, 0, '0, '0, mPc + 4, nm);
  endtask

  obs_t  got, want;
  string curName;
  initial forever begin
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      want = expQ.pop_front();
      curName = nameQ.pop_front();
      got = '{atual_pc, id_proc, quantum_exp, ativo, pc_salvo};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got pc=%0d id=%0d qexp=%0b ativo=%b salvo=%0d, want pc=%0d id=%0d qexp=%0b ativo=%b salvo=%0d",
                 curName, got.pc, got.id, got.qe, got.at, got.ps, want.pc, want.id, want.qe, want.at, want.ps);
      end
    end
  end

  task automatic checkReset(input string nm);
    checks++;
    if (atual_pc !== '0 || id_proc !== '0 || ativo !== 4'b0001 || quantum_exp !== 1'b0 || pc_salvo !== '0) begin
      errors++;
      $display("FAIL %s: got pc=%0d id=%0d ativo=%b qexp=%0b salvo=%0d, want pc=0 id=0 ativo=0001 qexp=0 salvo=0",
               nm, atual_pc, id_proc, ativo, quantum_exp, pc_salvo);
    end
  endtask

  task automatic randomRun(input int n);
    logic h, t, r, c;
    logic [W-1:0] nv;
    for (int k = 0; k < n; k++) begin
      h = ($urandom_range(0, 99) < 4);
      t = ($urandom_range(0, 99) < 12);
      r = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 30);
      nv = ($urandom_range(0, 3) == 0) ? W'($urandom) : mPc + 4;
      drive(h, t, r, c, IW'($urandom_range(0, NP - 1)), W'($urandom), nv, "random");
    end
  endtask

  initial begin
    mreset();
    #1 reset = 0;
    #1 checkReset("reset_initial");
    @(negedge clk);
    reset = 1;

    drive(0, 0, 0, 1, 2'd1, 100, 4, "carga_1");
    drive(0, 0, 1, 0, 2'd1, 0, 8, "retoma_1");
    idle("run_1");
    drive(0, 1, 0, 0, 2'd1, 0, 120, "troca_save_120");
    drive(0, 0, 1, 0, 2'd1, 0, 72, "retoma_restore_120");
    drive(0, 0, 1, 0, 2'd2, 0, 50, "retoma_ignored_user");
    drive(0, 1, 0, 1, 2'd1, 777, 130, "save_beats_carga");
    drive(0, 0, 1, 1, 2'd1, 999, 72, "retoma_reads_old");
    drive(0, 1, 0, 0, 2'd1, 0, 140, "troca_back_os");
    drive(0, 1, 0, 0, 2'd0, 0, 9, "troca_ignored_os");

    drive(0, 0, 0, 1, 2'd2, 200, 13, "carga_2");
    drive(0, 0, 1, 0, 2'd2, 0, 17, "retoma_2");
    for (int i = 0; i < 4; i++) idle("slice_run");
    idle("slice_expire");
    idle("slice_pulse_end");

    drive(0, 0, 0, 1, 2'd3, 300, 21, "carga_3");
    drive(0, 0, 1, 0, 2'd3, 0, 25, "retoma_3");
    drive(1, 1, 0, 0, 2'd3, 0, 304, "halt_beats_troca");
    drive(1, 0, 0, 0, 2'd3, 0, 500, "halt_os");
    drive(0, 0, 1, 0, 2'd2, 0, 4, "retoma_2_again");
    drive(0, 1, 1, 0, 2'd2, 0, 32'hFFFF_FFFF, "troca_max_pc");
    drive(0, 0, 1, 0, 2'd2, 0, 8, "retoma_max_pc");
    idle("pc_wrap");

    randomRun(1500);

    drive(0, 0, 0, 1, 2'd2, 500, mPc + 4, "carga_pre_reset");
    if (mId != 0) drive(0, 1, 0, 0, 2'd0, 0, mPc + 4, "to_os_pre_reset");
    drive(0, 0, 1, 0, 2'd2, 0, mPc + 4, "retoma_pre_reset");
    idle("run_pre_reset");
    @(posedge clk);
    #3 reset = 0;
    #1 checkReset("reset_async_midrun");
    mreset();
    @(negedge clk);
    reset = 1;
    idle("after_reset");
    drive(0, 0, 1, 0, 2'd2, 0, 4, "retoma_after_reset");
    randomRun(300);

    @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gerencia_pc_ctx.md
Name: gerencia_pc_ctx

Overview:
- Parametrised program-counter manager with hardware context save/restore for NPROC processes; process 0 is the OS.
- Registers the PC every cycle and owns the current process id.
- On a user-process context switch, halt or time-slice expiry, it saves the resume PC into a per-process table and vectors into OS handler code.
- On an OS resume request, it restores a saved PC. Sits between the next-PC mux and instruction memory.

Parameters:
- WIDTH, 32, PC width in bits
- NPROC, 4, number of processes including OS (id 0); power of two, 2..16
- IDW, $clog2(NPROC), process id width (derived)
- HALT_VEC, 67, OS handler address for user-process halt
- CTX_VEC, 68, OS handler address for context switch
- OS_ENTRY, 0, OS restart address
- QUANTUM, 0, time slice in cycles for user processes; 0 disables the timer

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- novo_pc  in  WIDTH  next PC from the datapath
- halt  in  1  HALT instruction executing
- troca_ctx  in  1  software context-switch request
- retoma  in  1  OS request to resume process id_alvo
- carga  in  1  write pc_carga into table[id_alvo]
- id_alvo  in  IDW  target process for retoma/carga/read
- pc_carga  in  WIDTH  initial PC for carga
- atual_pc  out  WIDTH  registered current PC
- id_proc  out  IDW  registered current process id
- quantum_exp  out  1  one-cycle pulse: time slice expired this cycle
- pc_salvo  out  WIDTH  combinational read of table[id_alvo]
- ativo  out  NPROC  per-process valid bits (bit 0 always 1)

Behaviour:
- Reset (reset=0, asynchronous):
  - atual_pc=OS_ENTRY, id_proc=0, quantum_exp=0, slice counter=0.
  - All table entries 0; ativo = 1 in bit 0, 0 elsewhere.
  - Release is synchronous to the next clk edge. Reset mid-switch discards any pending save.
- Per-edge priority, highest first: halt > retoma > switch (troca_ctx, or quantum expiry) > normal. Exactly one action per cycle.
- halt:
  - id_proc==0: atual_pc<=OS_ENTRY; nothing else changes.
  - id_proc!=0: atual_pc<=HALT_VEC; ativo[id_proc]<=0; id_proc<=0; counter<=0. No save.
- retoma, honoured only if id_proc==0 and id_alvo!=0:
  - atual_pc<=table[id_alvo], id_proc<=id_alvo, ativo[id_alvo]<=1, counter<=0.
  - Otherwise ignored, and the lower-priority action applies.
- switch, honoured only if id_proc!=0:
  - table[id_proc]<=novo_pc (resume point); atual_pc<=CTX_VEC; id_proc<=0; counter<=0.
  - troca_ctx while id_proc==0 is ignored.
- Quantum timer (QUANTUM>0):
  - counter increments each cycle while id_proc!=0 and no higher action occurs.
  - When counter==QUANTUM-1, that edge performs a switch and quantum_exp is 1 for that cycle. quantum_exp is registered and asserted in the cycle after the edge.
  - troca_ctx coincident with expiry gives a single switch, and quantum_exp still pulses.
- normal: atual_pc<=novo_pc. WIDTH-bit PC wraps modulo 2^WIDTH with no flag.
- carga:
  - Independent of the above; writes table[id_alvo]<=pc_carga at the edge. Ignored when id_alvo==0.
  - Same edge as a switch save to the same entry: the save wins.
  - Same edge as retoma of the same id: retoma reads the old value.
- Table: NPROC x WIDTH flops; entry 0 unused and reads 0.

Decomposition:
- Shared package gerencia_pkg holds:
  - HALT_VEC, CTX_VEC, OS_ENTRY defaults
  - OS_ID=0
  - action enum {ACT_NORMAL, ACT_HALT, ACT_RETOMA, ACT_SWITCH}
- One sub-module, contexto_tab: register file with one write port for the save, one for carga (priority resolved inside) and one async read port for retoma and pc_salvo.
- Priority decode and the slice counter stay in the top.

Test Plan:
- Reset low mid-run with id_proc=2 -> atual_pc=0, id_proc=0, ativo=4'b0001 immediately, without waiting for clk.
- carga id_alvo=1 pc_carga=100, then retoma id_alvo=1 -> next edge atual_pc=100, id_proc=1, ativo=4'b0011.
- Running id 1, novo_pc=120, troca_ctx=1 -> atual_pc=68, id_proc=0, pc_salvo(id 1)=120; retoma id 1 -> atual_pc=120.
- QUANTUM=5, id 2 running, no events -> switch on the 5th edge after resume: atual_pc=68, quantum_exp high for exactly one cycle.
- halt and troca_ctx together with id_proc=3 -> atual_pc=67, ativo[3]=0, table[3] unchanged; halt with id_proc=0 -> atual_pc=0.
- Ignored cases:
  - troca_ctx with id_proc=0 and novo_pc=9 -> atual_pc=9.
  - retoma while id_proc=1 -> ignored; normal advance applies.
